// File: rtl/xor_checksum_accumulator.sv
// Per-packet XOR checksum with parity, saturating word count and overflow flag.
// One result is held for the consumer after each packet's last word.
module xor_checksum_accumulator #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_WORDS = 16,
  localparam int unsigned CNT_W    = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  input  logic             up_last,
  input  logic             odd_mode,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [WIDTH-1:0] down_checksum,
  output logic             down_parity,
  output logic [CNT_W-1:0] down_count,
  output logic             down_overflow
);

  typedef enum logic {ACC, HOLD} state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   acc, acc_next;
  logic [CNT_W-1:0]   count, count_next;
  logic               overflow, overflow_next;
  logic               odd_q, odd_next;
  logic               parity, parity_next;

  // State and packet registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACC;
      acc      <= '0;
      count    <= '0;
      overflow <= 1'b0;
      odd_q    <= 1'b0;
      parity   <= 1'b0;
    end else begin
      state    <= state_next;
      acc      <= acc_next;
      count    <= count_next;
      overflow <= overflow_next;
      odd_q    <= odd_next;
      parity   <= parity_next;
    end
  end

  // Next-state and datapath update; count==0 marks the first word of a packet.
  always_comb begin
    state_next    = state;
    acc_next      = acc;
    count_next    = count;
    overflow_next = overflow;
    odd_next      = odd_q;
    unique case (state)
      ACC: begin
        if (up_valid) begin
          if (count == '0) begin
            acc_next      = up_data;
            count_next    = CNT_W'(1);
            overflow_next = 1'b0;
            odd_next      = odd_mode;
          end else begin
            acc_next = acc ^ up_data;
            if (count == CNT_W'(MAX_WORDS)) begin
              overflow_next = 1'b1;
            end else begin
              count_next = count + CNT_W'(1);
            end
          end
          if (up_last) begin
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (down_ready) begin
          state_next = ACC;
          count_next = '0;
        end
      end
      default: state_next = ACC;
    endcase
    // Parity is registered alongside the checksum so it is stable while held.
    parity_next = (^acc_next) ^ odd_next;
  end

  assign up_ready      = (state == ACC);
  assign down_valid    = (state == HOLD);
  assign down_checksum = acc;
  assign down_parity   = parity;
  assign down_count    = count;
  assign down_overflow = overflow;

endmodule

// File: tb/tb_xor_checksum_accumulator.sv
// Directed bench: three instances (8b/16, 8b/4, 1b/16) share one control stream.
module tb_xor_checksum_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       up_valid;
  logic [7:0] up_data;
  logic       up_last;
  logic       odd_mode;
  logic       down_ready;

  logic       a_up_ready, a_down_valid, a_parity, a_overflow;
  logic [7:0] a_checksum;
  logic [4:0] a_count;
  logic       b_up_ready, b_down_valid, b_parity, b_overflow;
  logic [7:0] b_checksum;
  logic [2:0] b_count;
  logic       c_up_ready, c_down_valid, c_parity, c_overflow;
  logic [0:0] c_checksum;
  logic [4:0] c_count;

  int total = 0;
  int bad   = 0;
  int res_a = 0;
  int res_c = 0;
  int snap;

  always #5 clk = ~clk;

  xor_checksum_accumulator #(.WIDTH(8), .MAX_WORDS(16)) dut_a (
    .clk(clk), .rst(rst), .up_valid(up_valid), .up_ready(a_up_ready),
    .up_data(up_data), .up_last(up_last), .odd_mode(odd_mode),
    .down_valid(a_down_valid), .down_ready(down_ready),
    .down_checksum(a_checksum), .down_parity(a_parity),
    .down_count(a_count), .down_overflow(a_overflow)
  );

  xor_checksum_accumulator #(.WIDTH(8), .MAX_WORDS(4)) dut_b (
    .clk(clk), .rst(rst), .up_valid(up_valid), .up_ready(b_up_ready),
    .up_data(up_data), .up_last(up_last), .odd_mode(odd_mode),
    .down_valid(b_down_valid), .down_ready(down_ready),
    .down_checksum(b_checksum), .down_parity(b_parity),
    .down_count(b_count), .down_overflow(b_overflow)
  );

  xor_checksum_accumulator #(.WIDTH(1), .MAX_WORDS(16)) dut_c (
    .clk(clk), .rst(rst), .up_valid(up_valid), .up_ready(c_up_ready),
    .up_data(up_data[0:0]), .up_last(up_last), .odd_mode(odd_mode),
    .down_valid(c_down_valid), .down_ready(down_ready),
    .down_checksum(c_checksum), .down_parity(c_parity),
    .down_count(c_count), .down_overflow(c_overflow)
  );

  // Count completed result handshakes per instance.
  always @(posedge clk) begin
    if (!rst && a_down_valid && down_ready) res_a = res_a + 1;
    if (!rst && c_down_valid && down_ready) res_c = res_c + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present one word for a single cycle; called at a negedge, returns at the next.
  task automatic word(input logic [7:0] d, input logic l, input logic o);
    up_valid = 1'b1;
    up_data  = d;
    up_last  = l;
    odd_mode = o;
    @(negedge clk);
    up_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; up_valid = 1'b0; up_data = '0; up_last = 1'b0;
    odd_mode = 1'b0; down_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_up_ready", 32'(a_up_ready), 32'd1);
    check("rst_down_valid", 32'(a_down_valid), 32'd0);
    check("rst_count", 32'(a_count), 32'd0);
    check("rst_checksum", 32'(a_checksum), 32'd0);
    check("rst_overflow", 32'(a_overflow), 32'd0);
    rst = 1'b0;

    // Single-word packet.
    down_ready = 1'b1;
    word(8'hA5, 1'b1, 1'b0);
    check("single_valid", 32'(a_down_valid), 32'd1);
    check("single_checksum", 32'(a_checksum), 32'hA5);
    check("single_parity", 32'(a_parity), 32'd0);
    check("single_count", 32'(a_count), 32'd1);
    check("single_overflow", 32'(a_overflow), 32'd0);
    @(negedge clk);
    check("single_done_valid", 32'(a_down_valid), 32'd0);
    check("single_done_ready", 32'(a_up_ready), 32'd1);

    // Three words, even sense; odd_mode flips mid-packet and must be ignored.
    down_ready = 1'b0;
    word(8'h0F, 1'b0, 1'b0);
    word(8'hF0, 1'b0, 1'b1);
    word(8'h01, 1'b1, 1'b1);
    check("three_checksum", 32'(a_checksum), 32'hFE);
    check("three_parity_even", 32'(a_parity), 32'd1);
    check("three_count", 32'(a_count), 32'd3);

    // Back-pressure: result held, inputs ignored.
    up_valid = 1'b1; up_data = 8'h77; up_last = 1'b1; odd_mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(a_down_valid), 32'd1);
      check("hold_up_ready", 32'(a_up_ready), 32'd0);
      check("hold_checksum", 32'(a_checksum), 32'hFE);
      check("hold_parity", 32'(a_parity), 32'd1);
      check("hold_count", 32'(a_count), 32'd3);
    end
    down_ready = 1'b1;
    @(negedge clk);
    up_valid = 1'b0;
    check("release_valid", 32'(a_down_valid), 32'd0);
    check("release_up_ready", 32'(a_up_ready), 32'd1);

    // Same words, odd sense captured at first word.
    word(8'h0F, 1'b0, 1'b1);
    word(8'hF0, 1'b0, 1'b0);
    word(8'h01, 1'b1, 1'b0);
    check("odd_checksum", 32'(a_checksum), 32'hFE);
    check("odd_parity", 32'(a_parity), 32'd0);
    check("odd_count", 32'(a_count), 32'd3);
    @(negedge clk);

    // Saturation on the MAX_WORDS=4 instance.
    for (int i = 0; i < 6; i++) word(8'h01, 1'(i == 5), 1'b0);
    check("sat_checksum", 32'(b_checksum), 32'h00);
    check("sat_count", 32'(b_count), 32'd4);
    check("sat_overflow", 32'(b_overflow), 32'd1);
    check("sat_parity", 32'(b_parity), 32'd0);
    check("nosat_count", 32'(a_count), 32'd6);
    check("nosat_overflow", 32'(a_overflow), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) word(8'h01, 1'(i == 3), 1'b0);
    check("edge_count", 32'(b_count), 32'd4);
    check("edge_overflow", 32'(b_overflow), 32'd0);
    @(negedge clk);

    // Abort a partial packet with reset; reset beats a concurrent accept.
    snap = res_a;
    word(8'h11, 1'b0, 1'b0);
    word(8'h22, 1'b0, 1'b0);
    rst = 1'b1; up_valid = 1'b1; up_data = 8'h55; up_last = 1'b1;
    @(negedge clk);
    rst = 1'b0; up_valid = 1'b0;
    check("abort_valid", 32'(a_down_valid), 32'd0);
    check("abort_up_ready", 32'(a_up_ready), 32'd1);
    check("abort_count", 32'(a_count), 32'd0);
    word(8'h3C, 1'b1, 1'b0);
    check("post_abort_checksum", 32'(a_checksum), 32'h3C);
    check("post_abort_count", 32'(a_count), 32'd1);
    @(negedge clk);
    check("abort_results", 32'(res_a - snap), 32'd1);

    // WIDTH=1 packets {1}, {1,1}, {1,0,1,1}.
    snap = res_c;
    word(8'h01, 1'b1, 1'b0);
    check("w1_p1_checksum", 32'(c_checksum), 32'd1);
    check("w1_p1_count", 32'(c_count), 32'd1);
    @(negedge clk);
    word(8'h01, 1'b0, 1'b0);
    word(8'h01, 1'b1, 1'b0);
    check("w1_p2_checksum", 32'(c_checksum), 32'd0);
    check("w1_p2_count", 32'(c_count), 32'd2);
    @(negedge clk);
    word(8'h01, 1'b0, 1'b0);
    word(8'h00, 1'b0, 1'b0);
    word(8'h01, 1'b0, 1'b0);
    word(8'h01, 1'b1, 1'b0);
    check("w1_p3_checksum", 32'(c_checksum), 32'd1);
    check("w1_p3_parity", 32'(c_parity), 32'd1);
    check("w1_p3_count", 32'(c_count), 32'd4);
    @(negedge clk);
    check("w1_results", 32'(res_c - snap), 32'd3);
    check("w1_idle_valid", 32'(c_down_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
